// File: rtl/framing_1024_ctrl.sv
// Frame sequencer for the 1024-deep, 16-bit prefetch framing FIFO.
// Admits the sample stream into an external show-ahead FIFO and tracks its
// occupancy. Once a full frame is buffered, it drains FRAME_LEN samples as one
// SOF/EOF-delimited burst. It also enforces a minimum idle gap between bursts.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for en and a full frame's worth of samples
// S_STREAM | draining one frame; beat_cnt tracks position in frame
// S_GAP    | enforced idle after EOF; gap_cnt counts down to zero
module framing_1024_ctrl #(
  parameter int DATA_W     = 16,
  parameter int DEPTH_W    = 10,
  parameter int FRAME_LEN  = 1024,
  parameter int GAP_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_wr_data,
  input  logic              fifo_wr_vld,
  output logic              fifo_rd_en,
  input  logic              fifo_rd_vld,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sof,
  output logic              out_eof,
  output logic [15:0]       frame_cnt,
  output logic              overflow,
  output logic              busy
);

  localparam int CNT_W = DEPTH_W + 1;
  localparam logic [CNT_W-1:0] FRAME_LEN_C = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_BEAT_C = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] FILL_MAX_C  = CNT_W'(2 ** DEPTH_W);
  localparam bit               HAS_GAP     = (GAP_CYCLES > 0);
  // Gap timer is loaded with GAP_CYCLES-1 so that S_GAP lasts exactly GAP_CYCLES cycles.
  localparam logic [7:0]       GAP_LOAD_C  = 8'(HAS_GAP ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_GAP    = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] fill_cnt;
  logic [CNT_W-1:0] beat_cnt;
  logic [7:0]       gap_cnt;
  logic             wr_acc;
  logic             rd_beat;
  logic             streaming;

  // Write side is a pure pass-through gated by FIFO space.
  assign in_ready     = fifo_wr_vld;
  assign fifo_wr_en   = in_valid & fifo_wr_vld;
  assign fifo_wr_data = in_data;
  assign wr_acc       = in_valid & fifo_wr_vld;

  // Read side: zero-latency view of the show-ahead FIFO head while streaming.
  assign streaming  = (state == S_STREAM);
  assign out_valid  = streaming & fifo_rd_vld;
  assign out_data   = fifo_rd_data;
  assign fifo_rd_en = streaming & out_ready;
  assign rd_beat    = out_valid & out_ready;
  assign out_sof    = (beat_cnt == '0);
  assign out_eof    = (beat_cnt == LAST_BEAT_C);
  assign busy       = (state != S_IDLE);

  // Occupancy tracking; saturates at both ends so a misbehaving FIFO cannot wrap it.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_cnt <= '0;
    end else begin
      case ({wr_acc, rd_beat})
        2'b10: if (fill_cnt != FILL_MAX_C) fill_cnt <= fill_cnt + CNT_W'(1);
        2'b01: if (fill_cnt != '0)         fill_cnt <= fill_cnt - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Sticky drop flag: any offered sample that found the FIFO full.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (in_valid && !fifo_wr_vld) begin
      overflow <= 1'b1;
    end
  end

  // Frame sequencer: start on full frame, count beats, then time the inter-frame gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      beat_cnt  <= '0;
      gap_cnt   <= '0;
      frame_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (en && (fill_cnt >= FRAME_LEN_C)) begin
            state    <= S_STREAM;
            beat_cnt <= '0;
          end
        end
        S_STREAM: begin
          if (rd_beat) begin
            if (beat_cnt == LAST_BEAT_C) begin
              frame_cnt <= frame_cnt + 16'd1;
              beat_cnt  <= '0;
              if (HAS_GAP) begin
                state   <= S_GAP;
                gap_cnt <= GAP_LOAD_C;
              end else begin
                state <= S_IDLE;
              end
            end else begin
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == 8'd0) begin
            state <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
